// File: rtl/apb_completer_regfile.sv
// APB completer with a word-addressed register file, a decoded address window
// and a fixed number of inserted wait states. All APB outputs are registered.
module apb_completer_regfile #(
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 16,
    parameter int BASE_ADDR   = 0,
    parameter int DEPTH       = 512,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  PCLK,
    input  logic                  PRESETN,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR
);

    // One extra bit so addresses below the base never wrap into the window.
    localparam int OFF_W = ADDR_WIDTH + 1;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [OFF_W-1:0] BASE_EXT  = OFF_W'(BASE_ADDR);
    localparam logic [OFF_W-1:0] DEPTH_EXT = OFF_W'(DEPTH);
    localparam logic [3:0]       WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS} state_t;

    localparam state_t FIRST_STATE = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;

    state_t                state_q, state_d;
    logic [3:0]            wait_cnt_q, wait_cnt_d;
    logic                  wr_q, wr_d;
    logic                  ok_q, ok_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  pready_q, pready_d;
    logic                  pslverr_q, pslverr_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [OFF_W-1:0]      paddr_ext;
    logic [OFF_W-1:0]      offset;
    logic                  addr_ok;
    logic                  mem_we;

    // Window decode of the live address, used at setup time.
    always_comb begin
        paddr_ext = {1'b0, PADDR};
        offset    = paddr_ext - BASE_EXT;
        addr_ok   = (paddr_ext >= BASE_EXT) && (offset < DEPTH_EXT);
    end

    // Control state and registered APB outputs.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= '0;
            wr_q       <= 1'b0;
            ok_q       <= 1'b0;
            pready_q   <= 1'b0;
            pslverr_q  <= 1'b0;
            prdata_q   <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            wr_q       <= wr_d;
            ok_q       <= ok_d;
            pready_q   <= pready_d;
            pslverr_q  <= pslverr_d;
            prdata_q   <= prdata_d;
        end
    end

    // Captured address index and write data; only meaningful once captured.
    always_ff @(posedge PCLK) begin
        idx_q   <= idx_d;
        wdata_q <= wdata_d;
    end

    // Register file storage; written only at a completing in-range write.
    always_ff @(posedge PCLK) begin
        if (mem_we) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    // Next-state logic: setup capture, wait countdown, abort and completion.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        wr_d       = wr_q;
        ok_d       = ok_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        mem_we     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (PSEL && !PENABLE) begin
                    wr_d       = PWRITE;
                    ok_d       = addr_ok;
                    idx_d      = offset[IDX_W-1:0];
                    wdata_d    = PWDATA;
                    wait_cnt_d = WAIT_INIT;
                    state_d    = FIRST_STATE;
                end
            end
            S_WAIT: begin
                if (PSEL && PENABLE) begin
                    if (wait_cnt_q <= 4'd1) begin
                        state_d = S_ACCESS;
                    end else begin
                        wait_cnt_d = wait_cnt_q - 4'd1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACCESS: begin
                state_d = S_IDLE;
                mem_we  = PSEL && PENABLE && wr_q && ok_q;
            end
            default: state_d = S_IDLE;
        endcase
    end

    logic             sel_wr;
    logic             sel_ok;
    logic [IDX_W-1:0] sel_idx;

    // Output logic: load PREADY/PSLVERR/PRDATA for the cycle spent in ACCESS.
    always_comb begin
        // Entering ACCESS straight from IDLE must use the live setup values.
        sel_wr    = (state_q == S_IDLE) ? PWRITE : wr_q;
        sel_ok    = (state_q == S_IDLE) ? addr_ok : ok_q;
        sel_idx   = (state_q == S_IDLE) ? offset[IDX_W-1:0] : idx_q;
        pready_d  = (state_d == S_ACCESS);
        pslverr_d = (state_d == S_ACCESS) && !sel_ok;
        prdata_d  = '0;
        if ((state_d == S_ACCESS) && !sel_wr && sel_ok) begin
            prdata_d = mem_q[sel_idx];
        end
    end

    assign PREADY  = pready_q;
    assign PSLVERR = pslverr_q;
    assign PRDATA  = prdata_q;

endmodule

// File: doc/apb_completer_regfile.md
# apb_completer_regfile

APB completer holding a word-addressed 16-bit register file, serving the `apb_top` requester on the completer side of the single-requester/multi-completer fabric. It decodes its own address window, inserts a programmable number of wait states, and drives PREADY, PRDATA and PSLVERR. One instance sits behind each PSEL line from the fabric decoder.

## Interface
- ADDR_WIDTH, 10, width of PADDR (word address).
- DATA_WIDTH, 16, width of PWDATA/PRDATA and of each register.
- BASE_ADDR, 0, first word address owned by this instance.
- DEPTH, 512, number of registers; valid window is BASE_ADDR .. BASE_ADDR+DEPTH-1.
- WAIT_CYCLES, 1, wait states inserted per transfer (0..15).

Ports:
- PCLK  in  1  clock; all state updates on the rising edge.
- PRESETN  in  1  asynchronous, active-low reset.
- PSEL  in  1  completer select from the fabric decoder.
- PENABLE  in  1  access-phase indicator.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDR_WIDTH  word address.
- PWDATA  in  DATA_WIDTH  write data.
- PRDATA  out  DATA_WIDTH  read data; valid only while PREADY=1 on a read.
- PREADY  out  1  transfer completes at the edge where PSEL&PENABLE&PREADY.
- PSLVERR  out  1  error flag; valid only while PREADY=1.

## Operation
- All outputs are registered. Reset value of PRDATA, PREADY and PSLVERR is 0; the FSM resets to IDLE. Register-file contents are not reset: read before first write returns X.
- Address check: offset = PADDR - BASE_ADDR, computed at ADDR_WIDTH+1 bits. In range only when PADDR >= BASE_ADDR and offset < DEPTH. Out-of-range addresses must not wrap.
- FSM states:
  - IDLE: PREADY=0. If PSEL=1 and PENABLE=0 (setup phase), capture PADDR, PWRITE and PWDATA, plus the range result, and load wait_cnt=WAIT_CYCLES. Go to ACCESS if WAIT_CYCLES=0, otherwise WAIT. PSEL=1 with PENABLE=1 in IDLE has no setup phase, so it is ignored and PREADY stays 0.
  - WAIT: PREADY=0. If PSEL=1 and PENABLE=1, decrement wait_cnt; when wait_cnt reaches 1, go to ACCESS.
  - ACCESS: PREADY=1 for exactly one cycle, then IDLE. PSLVERR = out-of-range. On an in-range read, PRDATA = regfile[offset] (loaded on entry). On an error or a write, PRDATA = 0.
- Writes commit to regfile[offset] at the completing edge (ACCESS with PSEL&PENABLE), and only when PWRITE=1 and the address is in range. Error writes change nothing.
- Captured address and data are used. PADDR/PWDATA changes after setup have no effect.
- Abort: if PSEL or PENABLE drops in WAIT or ACCESS, return to IDLE next edge. No write occurs, and PREADY, PSLVERR and PRDATA go to 0.
- Back-to-back transfers: a setup phase in the cycle after ACCESS is accepted normally from IDLE.
- Reset asserted mid-transfer: outputs clear immediately (asynchronous) and the FSM goes to IDLE. No write commits for the interrupted transfer.

## Timing
- Setup phase is cycle T1. Access phase starts at T2. PREADY is high in cycle T2+WAIT_CYCLES, and the transfer completes at the end of that cycle.
- Total transfer length is 2+WAIT_CYCLES cycles. The minimum back-to-back period is 2+WAIT_CYCLES cycles, with no idle cycle required.
- A write is visible to a read whose setup phase starts in the cycle after the write completes.
- PREADY is never high for two consecutive cycles.

## Test plan
- WAIT_CYCLES=1, BASE_ADDR=0: write 0xBB22 to 0x001, then read 0x001. Each transfer lasts 3 cycles, with PREADY high in cycle 3 only. Read returns PRDATA=0xBB22 and PSLVERR=0.
- Out of range (DEPTH=512): write 0xBB33 to 0x3FE, then read 0x3FE. Both complete with PSLVERR=1 and PRDATA=0. A read of 0x002 shows no corruption of its earlier-written value.
- BASE_ADDR=0x200, DEPTH=512: write 0xBB55 to 0x3FF, then read it back, giving 0xBB55. Access to 0x1FF gives PSLVERR=1, with no underflow wrap.
- WAIT_CYCLES=0: back-to-back writes to 0x001/0x002 then reads, at 2 cycles per transfer. PREADY is high in every second cycle, and data reads back 0xBB22/0xBB44.
- Abort: drop PENABLE during WAIT of a write of 0xDEAD to 0x001. The FSM returns to IDLE and a following read of 0x001 still returns 0xBB22.
- Reset mid-transfer: assert PRESETN=0 during WAIT of a write. PREADY, PSLVERR and PRDATA go to 0 immediately. After release, a read returns the pre-reset value.
